// File: rtl/board_line_fetch.sv
// Per-scanline board row prefetch (hblank) with double-buffered currLine and CPU/video RAM arbitration.
// Latency: 3 clk trigger->pending, swap on next hcount 0 edge. CPU held off while fetch busy. Optional: LINE_FETCH_MISS_CNT_EN.
module board_line_fetch #(
    parameter int          ROWS      = 20,
    parameter int          BLOCK_PX  = 24,
    parameter int          V_TOTAL   = 525,
    parameter int          H_FETCH   = 640,
    parameter logic [15:0] BASE_ADDR = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [15:0] currLine,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
`ifdef LINE_FETCH_MISS_CNT_EN
    ,
    output logic [7:0]  miss_count
`endif
);

    localparam int PX_W  = $clog2(BLOCK_PX);
    localparam int ROW_W = $clog2(ROWS + 1);

    localparam logic [9:0]       H_FETCH_V = 10'(H_FETCH);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [PX_W-1:0]  PX_LAST   = PX_W'(BLOCK_PX - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t            state, state_nxt;
    logic [9:0]        prev_h;
    logic [PX_W-1:0]   px_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [15:0]       staging;
    logic              pending;
    logic              trigger;
    logic              line_start;
    logic              row_valid;
    logic              swap;

    // Edge detection on hcount makes both events one-shot regardless of pixel-enable rate.
    assign trigger    = (hcount == H_FETCH_V) && (prev_h != H_FETCH_V);
    assign line_start = (hcount == 10'd0) && (prev_h != 10'd0);
    assign row_valid  = (row_cnt < ROW_MAX);
    // A swap is deferred while a fetch is in flight so a half-built line is never shown.
    assign swap       = line_start && pending && (state == IDLE);

    assign mem_wdata = rst_n ? cpu_wdata : 16'h0000;

    always_comb begin
        state_nxt = state;
        mem_addr  = 16'h0000;
        mem_we    = 1'b0;
        cpu_gnt   = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = ISSUE;
                end else if (cpu_req && rst_n) begin
                    cpu_gnt  = 1'b1;
                    mem_addr = cpu_addr;
                    mem_we   = cpu_we;
                end
            end
            ISSUE: begin
                if (row_valid) begin
                    mem_addr  = BASE_ADDR + 16'(row_cnt);
                    state_nxt = CAPTURE;
                end else begin
                    state_nxt = DONE;
                end
            end
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h  <= 10'd0;
            px_cnt  <= '0;
            row_cnt <= '0;
        end else begin
            prev_h <= hcount;
            if (trigger) begin
                if (vcount == V_LAST) begin
                    px_cnt  <= '0;
                    row_cnt <= '0;
                end else if (px_cnt == PX_LAST) begin
                    px_cnt <= '0;
                    if (row_cnt != ROW_MAX) begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end else begin
                    px_cnt <= px_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging  <= 16'h0000;
            pending  <= 1'b0;
            currLine <= 16'h0000;
        end else begin
            if (state == ISSUE && !row_valid) begin
                staging <= 16'h0000;
            end else if (state == CAPTURE) begin
                staging <= mem_rdata;
            end

            if (state == DONE) begin
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end

            if (swap) begin
                currLine <= staging;
            end
        end
    end

`ifdef LINE_FETCH_MISS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= 8'd0;
        end else if (line_start && (state != IDLE) && (miss_count != 8'hFF)) begin
            miss_count <= miss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_board_line_fetch.sv
// Directed bench for board_line_fetch: one full frame of line triggers, CPU contention, mid-fetch reset, optional miss counter.
module tb_board_line_fetch;

    logic        clk;
    logic        rst_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] currLine;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef LINE_FETCH_MISS_CNT_EN
    logic [7:0]  miss_count;
`endif

    logic [15:0] ram [0:511];
    logic [15:0] exp_row [0:19];
    logic [15:0] exp_cur;
    int          n_cmp;
    int          n_bad;

    board_line_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .currLine  (currLine),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef LINE_FETCH_MISS_CNT_EN
        ,
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[8:0]];
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One compressed scanline: hcount 0 edge, then the hblank trigger and fetch.
    task automatic line(input int v, input int row, input bit do_chk, input bit cpu);
        logic [15:0] exp_addr;
        exp_addr = (row >= 0) ? 16'(16'h0100 + row) : 16'h0000;
        vcount = 10'(v);
        hcount = 10'd0;
        tick();
        @(negedge clk);
        if (do_chk) check_eq($sformatf("cur_v%0d", v), currLine, exp_cur);
        hcount = 10'd1;
        tick();
        hcount = 10'd640;
        if (cpu) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 16'h0105;
            cpu_wdata = 16'h0155;
        end
        @(negedge clk);
        if (cpu) check_eq("gnt_trig", {15'd0, cpu_gnt}, 16'd0);
        tick();
        hcount = 10'd641;
        @(negedge clk);
        if (do_chk) begin
            check_eq($sformatf("addr_v%0d", v), mem_addr, exp_addr);
            check_eq($sformatf("we_v%0d", v), {15'd0, mem_we}, 16'd0);
        end
        if (cpu) check_eq("gnt_issue", {15'd0, cpu_gnt}, 16'd0);
        tick();
        @(negedge clk);
        if (cpu) check_eq("gnt_capture", {15'd0, cpu_gnt}, 16'd0);
        tick();
        @(negedge clk);
        if (cpu) check_eq("gnt_done", {15'd0, cpu_gnt}, 16'd0);
        tick();
        @(negedge clk);
        if (cpu) begin
            check_eq("gnt_idle", {15'd0, cpu_gnt}, 16'd1);
            check_eq("cpu_we", {15'd0, mem_we}, 16'd1);
            check_eq("cpu_addr", mem_addr, 16'h0105);
            tick();
            cpu_req = 1'b0;
            cpu_we  = 1'b0;
            exp_row[5] = 16'h0155;
        end
        tick();
        exp_cur = (row >= 0) ? exp_row[row] : 16'h0000;
    endtask

    initial begin
        int l;
        int r;
        bit c;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        hcount = 10'd0;
        vcount = 10'd0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_wdata = 16'h0000;
        exp_cur = 16'h0000;
        for (int i = 0; i < 512; i++) ram[i] = 16'hDEAD;
        for (int i = 0; i < 20; i++) begin
            exp_row[i] = 16'hA000 + 16'(i * 16'h0111);
            ram[256 + i] = 16'hA000 + 16'(i * 16'h0111);
        end
        exp_row[0] = 16'h03FF;
        ram[256] = 16'h03FF;

        #12;
        check_eq("rst_cur", currLine, 16'h0000);
        check_eq("rst_we", {15'd0, mem_we}, 16'd0);
        check_eq("rst_gnt", {15'd0, cpu_gnt}, 16'd0);
        check_eq("rst_addr", mem_addr, 16'h0000);
        check_eq("rst_wdata", mem_wdata, 16'h0000);
        tick();
        rst_n = 1'b1;

        line(524, 0, 1'b1, 1'b0);
        for (int v = 0; v < 524; v++) begin
            l = v + 1;
            r = (l < 480) ? l / 24 : -1;
            c = (v == 0 || v == 1 || v == 22 || v == 23 || v == 118 || v == 119 ||
                 v == 120 || v == 455 || v == 456 || v == 478 || v == 479 ||
                 v == 480 || v == 481 || v == 523);
            line(v, r, c, v == 118);
        end
        line(524, 0, 1'b1, 1'b0);
        line(0, 0, 1'b1, 1'b0);
        line(1, 0, 1'b1, 1'b0);

        // Reset during CAPTURE with a CPU request pending.
        vcount = 10'd10;
        hcount = 10'd0;
        tick();
        hcount = 10'd1;
        tick();
        hcount = 10'd640;
        tick();
        hcount = 10'd641;
        tick();
        #2;
        rst_n = 1'b0;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        #1;
        check_eq("mid_rst_cur", currLine, 16'h0000);
        check_eq("mid_rst_we", {15'd0, mem_we}, 16'd0);
        check_eq("mid_rst_gnt", {15'd0, cpu_gnt}, 16'd0);
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cur = 16'h0000;
        line(10, 0, 1'b1, 1'b0);
        line(11, 0, 1'b1, 1'b0);

`ifdef LINE_FETCH_MISS_CNT_EN
        check_eq("miss_init", {8'd0, miss_count}, 16'd0);
        vcount = 10'd12;
        hcount = 10'd0;
        tick();
        hcount = 10'd1;
        tick();
        hcount = 10'd640;
        tick();
        hcount = 10'd0;
        tick();
        @(negedge clk);
        check_eq("miss_cnt", {8'd0, miss_count}, 16'd1);
        check_eq("miss_cur", currLine, exp_cur);
        hcount = 10'd1;
        tick();
        tick();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
